debounce_bank: RTL and testbench

Multi-channel, parametrised button debouncer for the front-panel controls of the MIDI design. It replaces per-button single-output debouncers. Per channel it produces:
- a debounced level;
- one-cycle press, release and auto-repeat pulses.

It also merges all channel events into one valid/ready event stream for the MIDI control logic. Channels are independent; the only shared resource is the event output register.

---
 rtl/debounce_pkg.sv | 27 ++
 rtl/debounce_channel.sv | 117 +++++++++++
 rtl/debounce_bank.sv | 143 ++++++++++++++
 tb/tb_debounce_bank.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and width helpers for the debounce bank.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Event codes carried on the merged event stream.
    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_PRESS   = 2'd1,
        EV_RELEASE = 2'd2,
        EV_REPEAT  = 2'd3
    } ev_type_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One button: 2-FF synchroniser, settle counter, hold timer,
//               debounced level and press/release/repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pressed,
    output logic released,
    output logic rpt
);

    localparam int                    c_SETTLE_W   = $clog2(SETTLE_CYCLES);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_MAX = c_SETTLE_W'(SETTLE_CYCLES - 1);

    logic                  r_s1;
    logic                  r_s2;
    logic [c_SETTLE_W-1:0] r_cnt;
    logic                  r_level;
    logic                  r_pressed;
    logic                  r_released;

    // s2 is about to take a new value, so its stable run restarts at this edge.
    logic w_s2_change;
    logic w_accept;
    logic w_rise;
    logic w_fall;

    assign w_s2_change = r_s1 ^ r_s2;
    assign w_accept    = (r_cnt == c_SETTLE_MAX) && (r_s2 != r_level);
    assign w_rise      = w_accept &  r_s2;
    assign w_fall      = w_accept & ~r_s2;

    // Synchroniser, settle counter, accepted level and its edge pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_cnt      <= '0;
            r_level    <= 1'b0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_s1       <= btn;
            r_s2       <= r_s1;
            if (w_s2_change) begin
                r_cnt <= '0;
            end else if (r_cnt != c_SETTLE_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_level <= r_s2;
            end
            r_pressed  <= w_rise;
            r_released <= w_fall;
        end
    end

    assign level    = r_level;
    assign pressed  = r_pressed;
    assign released = r_released;

    generate
        if (REPEAT_EN) begin : g_hold
            localparam int                  c_HOLD_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
            localparam logic [c_HOLD_W-1:0] c_LONG_END = c_HOLD_W'(LONG_CYCLES - 1);
            localparam logic [c_HOLD_W-1:0] c_REP_END  = c_HOLD_W'(REPEAT_CYCLES - 1);

            logic [c_HOLD_W-1:0] r_hold;
            logic                r_rep_phase;   // first repeat already issued
            logic                r_rpt;
            logic                w_fire;

            // A release edge wins over a repeat landing on the same cycle.
            assign w_fire = r_level && !w_fall &&
                            (r_hold == (r_rep_phase ? c_REP_END : c_LONG_END));

            // Hold timer: restarts after every repeat, idle while released.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_hold      <= '0;
                    r_rep_phase <= 1'b0;
                    r_rpt       <= 1'b0;
                end else if (!r_level || w_rise) begin
                    r_hold      <= '0;
                    r_rep_phase <= 1'b0;
                    r_rpt       <= 1'b0;
                end else if (w_fire) begin
                    r_hold      <= '0;
                    r_rep_phase <= 1'b1;
                    r_rpt       <= 1'b1;
                end else begin
                    r_hold      <= r_hold + 1'b1;
                    r_rpt       <= 1'b0;
                end
            end

            assign rpt = r_rpt;
        end else begin : g_no_hold
            assign rpt = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank
// Description : Bank of button debouncers merged into one valid/ready event
//               stream with per-channel pending bits and a sticky overflow.
//               The auto-repeat pulse port is named rpt ("repeat" is a
//               reserved word).
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = 8,
    parameter int SETTLE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           btn,
    output logic [CHANNELS-1:0]           level,
    output logic [CHANNELS-1:0]           pressed,
    output logic [CHANNELS-1:0]           released,
    output logic [CHANNELS-1:0]           rpt,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [ch_width(CHANNELS)-1:0] ev_ch,
    output logic [1:0]                    ev_type,
    output logic                          ev_overflow
);

    localparam int c_CW = ch_width(CHANNELS);

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            debounce_channel #(
                .SETTLE_CYCLES (SETTLE_CYCLES),
                .LONG_CYCLES   (LONG_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES),
                .REPEAT_EN     (REPEAT_EN)
            ) u_chan (
                .clk      (clk),
                .rst      (rst),
                .btn      (btn[g]),
                .level    (level[g]),
                .pressed  (pressed[g]),
                .released (released[g]),
                .rpt      (rpt[g])
            );
        end
    endgenerate

    logic [CHANNELS-1:0] r_pend_press;
    logic [CHANNELS-1:0] r_pend_release;
    logic [CHANNELS-1:0] r_pend_repeat;
    logic                r_ev_valid;
    logic [c_CW-1:0]     r_ev_ch;
    ev_type_t            r_ev_type;
    logic                r_ovf;

    logic [CHANNELS-1:0] w_any;
    logic [CHANNELS-1:0] w_onehot;
    logic                w_load;
    logic [CHANNELS-1:0] w_ld_p;
    logic [CHANNELS-1:0] w_ld_r;
    logic [CHANNELS-1:0] w_ld_t;
    logic [c_CW-1:0]     w_sel;
    ev_type_t            w_type;
    logic                w_ovf_set;

    // Lowest-index channel with work pending; isolate its bit as a one-hot.
    assign w_any    = r_pend_press | r_pend_release | r_pend_repeat;
    assign w_onehot = w_any & (~w_any + CHANNELS'(1));
    assign w_load   = (!r_ev_valid || ev_ready) && (|w_any);

    // Within the chosen channel: PRESS over RELEASE over REPEAT.
    assign w_ld_p = w_load ? (w_onehot & r_pend_press) : '0;
    assign w_ld_r = w_load ? (w_onehot & r_pend_release & ~r_pend_press) : '0;
    assign w_ld_t = w_load ? (w_onehot & r_pend_repeat & ~r_pend_release & ~r_pend_press) : '0;

    // Encode the selected channel index and event code.
    always_comb begin
        w_sel  = '0;
        w_type = EV_REPEAT;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_onehot[i]) begin
                w_sel = c_CW'(i);
            end
        end
        if (|w_ld_p) begin
            w_type = EV_PRESS;
        end else if (|w_ld_r) begin
            w_type = EV_RELEASE;
        end
    end

    // An event is lost when a pending bit is overwritten or cancelled while
    // still set and not being loaded into the output register this cycle.
    assign w_ovf_set = |( (pressed  & r_pend_press   & ~w_ld_p)
                        | (pressed  & r_pend_release & ~w_ld_r)
                        | (pressed  & r_pend_repeat  & ~w_ld_t)
                        | (released & r_pend_release & ~w_ld_r)
                        | (released & r_pend_repeat  & ~w_ld_t)
                        | (rpt      & r_pend_repeat  & ~w_ld_t) );

    // Pending bits: a new pulse wins over a same-cycle load clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_press   <= '0;
            r_pend_release <= '0;
            r_pend_repeat  <= '0;
            r_ovf          <= 1'b0;
        end else begin
            r_pend_press   <= pressed | (r_pend_press & ~w_ld_p);
            r_pend_release <= ~pressed & (released | (r_pend_release & ~w_ld_r));
            r_pend_repeat  <= ~pressed & ~released & (rpt | (r_pend_repeat & ~w_ld_t));
            r_ovf          <= r_ovf | w_ovf_set;
        end
    end

    // Output register: hold under backpressure, reload when free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ev_valid <= 1'b0;
            r_ev_ch    <= '0;
            r_ev_type  <= EV_NONE;
        end else if (w_load) begin
            r_ev_valid <= 1'b1;
            r_ev_ch    <= w_sel;
            r_ev_type  <= w_type;
        end else if (ev_ready) begin
            r_ev_valid <= 1'b0;
        end
    end

    assign ev_valid    = r_ev_valid;
    assign ev_ch       = r_ev_ch;
    assign ev_type     = r_ev_type;
    assign ev_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_bank
// Description : Directed and randomised bench for debounce_bank against a
//               behavioural model built from sample history and hold time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_bank;

    localparam int CH = 4;
    localparam int S  = 8;
    localparam int L  = 40;
    localparam int R  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn;
    logic [CH-1:0] level, pressed, released, rpt;
    logic          ev_valid, ev_ready, ev_overflow;
    logic [1:0]    ev_ch;
    logic [1:0]    ev_type;

    int checks = 0;
    int errors = 0;

    debounce_bank #(
        .CHANNELS      (CH),
        .SETTLE_CYCLES (S),
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R),
        .REPEAT_EN     (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .level       (level),
        .pressed     (pressed),
        .released    (released),
        .rpt         (rpt),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ch       (ev_ch),
        .ev_type     (ev_type),
        .ev_overflow (ev_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit       m_hist [CH][S+1];      // [0] = latest sampled btn
    logic [CH-1:0] m_level, m_pressed, m_released, m_rpt;
    logic [CH-1:0] m_pp, m_pr, m_pt;
    logic     m_valid, m_ovf;
    int       m_ch, m_type;
    int       m_press_cyc [CH];
    int       cyc;

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin
            for (int k = 0; k <= S; k++) m_hist[i][k] = 1'b0;
            m_press_cyc[i] = 0;
        end
        m_level = '0; m_pressed = '0; m_released = '0; m_rpt = '0;
        m_pp = '0; m_pr = '0; m_pt = '0;
        m_valid = 1'b0; m_ovf = 1'b0; m_ch = 0; m_type = 0; cyc = 0;
    endtask

    task automatic model_step();
        logic [CH-1:0] ldp, ldr, ldt, n_p, n_r, n_t;
        logic found, pp, pr, pt, v, eq;
        int sel, held;
        ldp = '0; ldr = '0; ldt = '0; found = 1'b0; sel = 0;
        // event output: lowest channel first, then PRESS/RELEASE/REPEAT
        for (int i = 0; i < CH; i++)
            if (!found && (m_pp[i] || m_pr[i] || m_pt[i])) begin found = 1'b1; sel = i; end
        if (found && (!m_valid || ev_ready)) begin
            m_valid = 1'b1; m_ch = sel;
            if (m_pp[sel])      begin m_type = 1; ldp[sel] = 1'b1; end
            else if (m_pr[sel]) begin m_type = 2; ldr[sel] = 1'b1; end
            else                begin m_type = 3; ldt[sel] = 1'b1; end
        end else if (ev_ready) begin
            m_valid = 1'b0;
        end
        // pending bits from last cycle's pulses
        for (int i = 0; i < CH; i++) begin
            pp = m_pp[i] & ~ldp[i]; pr = m_pr[i] & ~ldr[i]; pt = m_pt[i] & ~ldt[i];
            if (m_pressed[i]) begin
                if (pp || pr || pt) m_ovf = 1'b1;
                pp = 1'b1; pr = 1'b0; pt = 1'b0;
            end
            if (m_released[i]) begin
                if (pr || pt) m_ovf = 1'b1;
                pr = 1'b1; pt = 1'b0;
            end
            if (m_rpt[i]) begin
                if (pt) m_ovf = 1'b1;
                pt = 1'b1;
            end
            m_pp[i] = pp; m_pr[i] = pr; m_pt[i] = pt;
        end
        // level: previous S synchronised samples all agree and differ from level
        for (int i = 0; i < CH; i++) begin
            v = m_hist[i][1]; eq = 1'b1;
            for (int k = 2; k <= S; k++) if (m_hist[i][k] != v) eq = 1'b0;
            n_p[i] = eq &&  v && !m_level[i];
            n_r[i] = eq && !v &&  m_level[i];
            n_t[i] = 1'b0;
            if (m_level[i] && !n_r[i]) begin
                held = cyc - m_press_cyc[i];
                if (held >= L && ((held - L) % R) == 0) n_t[i] = 1'b1;
            end
            if (n_p[i]) m_press_cyc[i] = cyc;
            for (int k = S; k >= 1; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = btn[i];
            if (n_p[i]) m_level[i] = 1'b1;
            else if (n_r[i]) m_level[i] = 1'b0;
        end
        m_pressed = n_p; m_released = n_r; m_rpt = n_t;
        cyc++;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_clear();
        else      model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        chk("level", 32'(level), 32'(m_level));
        chk("pressed", 32'(pressed), 32'(m_pressed));
        chk("released", 32'(released), 32'(m_released));
        chk("repeat", 32'(rpt), 32'(m_rpt));
        chk("ev_valid", 32'(ev_valid), 32'(m_valid));
        chk("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
        if (m_valid) begin
            chk("ev_ch", 32'(ev_ch), 32'(m_ch));
            chk("ev_type", 32'(ev_type), 32'(m_type));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_pressed"}, 32'(pressed), 0);
        chk({tag, "_released"}, 32'(released), 0);
        chk({tag, "_repeat"}, 32'(rpt), 0);
        chk({tag, "_valid"}, 32'(ev_valid), 0);
        chk({tag, "_ch"}, 32'(ev_ch), 0);
        chk({tag, "_type"}, 32'(ev_type), 0);
        chk({tag, "_ovf"}, 32'(ev_overflow), 0);
    endtask

    int rise, vt, nv, np, nr, vch, vty, w, rep_n, rep_first, rep_last, rep_ev, rel_ev;
    int evq [$];
    int dwell [CH];

    initial begin
        rst = 1'b0; btn = '0; ev_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (20) tick();

        // ---- single press on channel 2 ----
        btn[2] = 1'b1; rise = 0; vt = 0; nv = 0; np = 0; vch = 0; vty = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (level[2] && rise == 0) rise = i;
            if (pressed[2]) np++;
            if (ev_valid) begin
                nv++;
                if (vt == 0) begin vt = i; vch = int'(ev_ch); vty = int'(ev_type); end
            end
        end
        chk("press_latency", rise, 10);
        chk("press_pulses", np, 1);
        chk("press_ev_latency", vt, 12);
        chk("press_ev_ch", vch, 2);
        chk("press_ev_type", vty, 1);
        chk("press_ev_cycles", nv, 1);
        btn[2] = 1'b0;
        repeat (20) tick();

        // ---- bounce on channel 0 ----
        np = 0; nr = 0; nv = 0; rise = 0;
        for (int k = 0; k < 8; k++) begin
            btn[0] = ~btn[0];
            for (int j = 0; j < 5; j++) begin
                tick();
                if (pressed[0]) np++;
                if (released[0]) nr++;
            end
        end
        btn[0] = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (level[0] && rise == 0) rise = i;
            if (pressed[0]) np++;
            if (released[0]) nr++;
            if (ev_valid && ev_ch == 2'd0 && ev_type == 2'd1) nv++;
        end
        chk("bounce_latency", rise, 10);
        chk("bounce_press_pulses", np, 1);
        chk("bounce_release_pulses", nr, 0);
        chk("bounce_press_events", nv, 1);
        btn[0] = 1'b0;
        repeat (20) tick();

        // ---- auto-repeat on channel 1 ----
        btn[1] = 1'b1; w = 0;
        do begin tick(); w++; end while (!pressed[1] && w < 20);
        chk("repeat_press_seen", 32'(pressed[1]), 1);
        rep_n = 0; rep_first = 0; rep_last = 0; rep_ev = 0; rel_ev = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (rpt[1]) begin
                rep_n++;
                if (rep_n == 1) rep_first = i;
                rep_last = i;
            end
            if (ev_valid && ev_ch == 2'd1 && ev_type == 2'd3) rep_ev++;
            if (i == 90) btn[1] = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ev_valid && ev_ch == 2'd1 && ev_type == 2'd2) rel_ev++;
        end
        chk("repeat_pulses", rep_n, 4);
        chk("repeat_first", rep_first, 40);
        chk("repeat_last", rep_last, 88);
        chk("repeat_events", rep_ev, 4);
        chk("repeat_release_event", rel_ev, 1);

        // ---- backpressure and arbitration ----
        ev_ready = 1'b0; btn[3] = 1'b1;
        repeat (3) tick();
        btn[1] = 1'b1;
        repeat (15) tick();
        chk("bp_valid", 32'(ev_valid), 1);
        chk("bp_ch", 32'(ev_ch), 3);
        chk("bp_type", 32'(ev_type), 1);
        repeat (5) tick();
        chk("bp_hold_valid", 32'(ev_valid), 1);
        chk("bp_hold_ch", 32'(ev_ch), 3);
        ev_ready = 1'b1;
        tick();
        chk("bp_next_valid", 32'(ev_valid), 1);
        chk("bp_next_ch", 32'(ev_ch), 1);
        chk("bp_next_type", 32'(ev_type), 1);
        tick();
        chk("bp_drained", 32'(ev_valid), 0);
        btn[3] = 1'b0; btn[1] = 1'b0;
        repeat (30) tick();

        // ---- overflow on channel 0 ----
        chk("ovf_before", 32'(ev_overflow), 0);
        ev_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            btn[0] = ~btn[0];
            repeat (12) tick();
        end
        chk("ovf_set", 32'(ev_overflow), 1);
        chk("ovf_held_ch", 32'(ev_ch), 0);
        chk("ovf_held_type", 32'(ev_type), 1);
        ev_ready = 1'b1;
        evq.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ev_valid) evq.push_back(int'(ev_ch) * 4 + int'(ev_type));
        end
        chk("ovf_remaining", evq.size(), 2);
        if (evq.size() == 2) begin
            chk("ovf_ev0", evq[0], 1);
            chk("ovf_ev1", evq[1], 2);
        end
        chk("ovf_sticky", 32'(ev_overflow), 1);

        // ---- reset mid-operation ----
        ev_ready = 1'b0; btn[1] = 1'b1;
        repeat (14) tick();
        btn[2] = 1'b1;
        repeat (4) tick();
        chk("pre_reset_valid", 32'(ev_valid), 1);
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) tick();
        rst = 1'b1; ev_ready = 1'b1; rise = 0; vt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (level[1] && rise == 0) rise = i;
            if (ev_valid && vt == 0) vt = i;
        end
        chk("post_reset_latency", rise, 10);
        chk("post_reset_ev_latency", vt, 12);
        btn = '0;
        repeat (20) tick();

        // ---- randomised traffic ----
        for (int c = 0; c < CH; c++) dwell[c] = $urandom_range(1, 70);
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < CH; c++) begin
                if (dwell[c] == 0) begin
                    btn[c] = ~btn[c];
                    dwell[c] = $urandom_range(1, 70);
                end else begin
                    dwell[c]--;
                end
            end
            ev_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
